// File: rtl/mem_fill_bridge_if.sv
// Bundles the miss-handler request, external memory and beat delivery channels
// of mem_fill_bridge. The bridge connects through the slave modport.
`timescale 1ns/1ps

interface mem_fill_bridge_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int WORD_WIDTH = 20,
  parameter int IDX_WIDTH  = 3
);
  logic [ADDR_WIDTH-1:0]   i_req_addr;
  logic                    i_req_valid;
  logic                    o_req_ready;
  logic [ADDR_WIDTH-1:0]   o_ext_addr;
  logic                    o_ext_rd_valid;
  logic                    i_ext_rd_ready;
  logic [WORD_WIDTH-1:0]   i_ext_data;
  logic                    i_ext_data_valid;
  logic                    o_ext_data_ready;
  logic [2*WORD_WIDTH-1:0] o_beat_data;
  logic [IDX_WIDTH-1:0]    o_beat_index;
  logic                    o_beat_valid;
  logic                    i_beat_ready;
  logic                    o_fill_done;
  logic                    o_busy;

  modport master (
    output i_req_addr, i_req_valid, i_ext_rd_ready, i_ext_data, i_ext_data_valid, i_beat_ready,
    input  o_req_ready, o_ext_addr, o_ext_rd_valid, o_ext_data_ready, o_beat_data,
           o_beat_index, o_beat_valid, o_fill_done, o_busy
  );

  modport slave (
    input  i_req_addr, i_req_valid, i_ext_rd_ready, i_ext_data, i_ext_data_valid, i_beat_ready,
    output o_req_ready, o_ext_addr, o_ext_rd_valid, o_ext_data_ready, o_beat_data,
           o_beat_index, o_beat_valid, o_fill_done, o_busy
  );
endinterface

// File: rtl/mem_fill_bridge.sv
// Block-fill bridge: one burst read per miss, word pairs packed into beats and queued
// in a small FIFO. Define CRITICAL_BEAT_FIRST_EN to fetch the missed beat first (wrap order).
`timescale 1ns/1ps

module mem_fill_bridge #(
  parameter int ADDR_WIDTH  = 16,
  parameter int WORD_WIDTH  = 20,
  parameter int BEAT_WORDS  = 2,
  parameter int BLOCK_WORDS = 16,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             i_halt,
  mem_fill_bridge_if.slave bus
);

  localparam int OFF_W  = $clog2(BLOCK_WORDS);
  localparam int CNT_W  = OFF_W + 1;
  localparam int IDX_W  = $clog2(BLOCK_WORDS / BEAT_WORDS);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int BEAT_W = BEAT_WORDS * WORD_WIDTH;

  typedef enum logic [1:0] {IDLE, ISSUE, COLLECT, DRAIN} state_t;

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic [CNT_W-1:0]      word_cnt_reg, word_cnt_next;
  logic [WORD_WIDTH-1:0] pack_reg, pack_next;
  logic [PTR_W-1:0]      wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0]      rd_ptr_reg, rd_ptr_next;
  logic [PTR_W:0]        fifo_cnt_reg, fifo_cnt_next;
  logic [BEAT_W-1:0]     fifo_data_reg [FIFO_DEPTH];
  logic [IDX_W-1:0]      fifo_idx_reg  [FIFO_DEPTH];

  logic             fifo_full, fifo_empty;
  logic             word_odd, last_word;
  logic             req_fire, rd_fire, data_ready, word_fire;
  logic             push, pop, last_pop;
  logic [IDX_W-1:0] beat_base, push_idx;
  logic [BEAT_W-1:0] push_data;

`ifdef CRITICAL_BEAT_FIRST_EN
  // Burst starts at the even word of the missed beat; memory wraps within the block.
  assign bus.o_ext_addr = addr_reg & ~ADDR_WIDTH'(1);
  assign beat_base      = IDX_W'(addr_reg[OFF_W-1:0] >> 1);
`else
  assign bus.o_ext_addr = addr_reg & ~ADDR_WIDTH'(BLOCK_WORDS - 1);
  assign beat_base      = '0;
`endif

  assign fifo_full  = (fifo_cnt_reg == (PTR_W+1)'(FIFO_DEPTH));
  assign fifo_empty = (fifo_cnt_reg == '0);
  assign word_odd   = word_cnt_reg[0];
  assign last_word  = (word_cnt_reg == CNT_W'(BLOCK_WORDS - 1));

  assign req_fire   = (state_reg == IDLE) && !i_halt && bus.i_req_valid;
  assign rd_fire    = (state_reg == ISSUE) && !i_halt && bus.i_ext_rd_ready;
  // Occupancy is taken before any same-cycle pop, so a full FIFO blocks odd words.
  assign data_ready = (state_reg == COLLECT) && !i_halt && (!word_odd || !fifo_full);
  assign word_fire  = data_ready && bus.i_ext_data_valid;
  assign push       = word_fire && word_odd;
  assign pop        = !fifo_empty && bus.i_beat_ready && !i_halt;
  assign last_pop   = (state_reg == DRAIN) && pop && (fifo_cnt_reg == (PTR_W+1)'(1));

  assign push_idx   = beat_base + IDX_W'(word_cnt_reg >> 1);
  assign push_data  = BEAT_W'({bus.i_ext_data, pack_reg});

  assign bus.o_req_ready      = (state_reg == IDLE) && !i_halt;
  assign bus.o_ext_rd_valid   = (state_reg == ISSUE);
  assign bus.o_ext_data_ready = data_ready;
  assign bus.o_beat_valid     = !fifo_empty;
  assign bus.o_beat_data      = fifo_data_reg[rd_ptr_reg];
  assign bus.o_beat_index     = fifo_idx_reg[rd_ptr_reg];
  assign bus.o_fill_done      = last_pop;
  assign bus.o_busy           = (state_reg != IDLE);

  always_comb begin
    state_next    = state_reg;
    addr_next     = addr_reg;
    word_cnt_next = word_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (req_fire) begin
          state_next    = ISSUE;
          addr_next     = bus.i_req_addr;
          word_cnt_next = '0;
        end
      end
      ISSUE: begin
        if (rd_fire) state_next = COLLECT;
      end
      COLLECT: begin
        if (word_fire) begin
          word_cnt_next = word_cnt_reg + 1'b1;
          if (last_word) state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (last_pop) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    pack_next     = pack_reg;
    wr_ptr_next   = wr_ptr_reg;
    rd_ptr_next   = rd_ptr_reg;
    fifo_cnt_next = fifo_cnt_reg;
    if (word_fire && !word_odd) pack_next = bus.i_ext_data;
    if (push) wr_ptr_next = wr_ptr_reg + 1'b1;
    if (pop)  rd_ptr_next = rd_ptr_reg + 1'b1;
    case ({push, pop})
      2'b10:   fifo_cnt_next = fifo_cnt_reg + 1'b1;
      2'b01:   fifo_cnt_next = fifo_cnt_reg - 1'b1;
      default: fifo_cnt_next = fifo_cnt_reg;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_reg    <= IDLE;
      addr_reg     <= '0;
      word_cnt_reg <= '0;
      pack_reg     <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      fifo_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      addr_reg     <= addr_next;
      word_cnt_reg <= word_cnt_next;
      pack_reg     <= pack_next;
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      fifo_cnt_reg <= fifo_cnt_next;
    end
  end

  // Entries are reset so the head reads zero out of reset.
  for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_fifo
    always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
        fifo_data_reg[gi] <= '0;
        fifo_idx_reg[gi]  <= '0;
      end else if (push && (wr_ptr_reg == PTR_W'(gi))) begin
        fifo_data_reg[gi] <= push_data;
        fifo_idx_reg[gi]  <= push_idx;
      end
    end
  end

endmodule

// File: tb/tb_mem_fill_bridge.sv
// Directed bench for mem_fill_bridge: normal fill, back-pressure, request stall,
// halt and mid-burst reset, with expectations for both CRITICAL_BEAT_FIRST_EN builds.
`timescale 1ns/1ps

module tb_mem_fill_bridge;

  logic clk = 1'b0;
  logic arst_n = 1'b0;
  logic halt = 1'b0;

  int n_checks = 0;
  int n_fail = 0;

  logic [39:0] obs_data [8];
  logic [2:0]  obs_idx  [8];
  int rf_words, rf_beats, rf_dones, rf_done_beat;
  logic rf_busy_after;

  mem_fill_bridge_if bus ();

  mem_fill_bridge dut (
    .clk    (clk),
    .arst_n (arst_n),
    .i_halt (halt),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [2:0] exp_base(input logic [15:0] a);
`ifdef CRITICAL_BEAT_FIRST_EN
    return a[3:1];
`else
    return (a == a) ? 3'd0 : 3'd0;
`endif
  endfunction

  function automatic logic [15:0] exp_ext_addr(input logic [15:0] a);
`ifdef CRITICAL_BEAT_FIRST_EN
    return {a[15:1], 1'b0};
`else
    return {a[15:4], 4'h0};
`endif
  endfunction

  // Request handshake followed by an immediate read accept; returns in COLLECT.
  task automatic issue(input logic [15:0] a);
    @(negedge clk);
    bus.i_req_addr = a;
    bus.i_req_valid = 1'b1;
    bus.i_ext_data_valid = 1'b0;
    @(negedge clk);
    bus.i_req_valid = 1'b0;
    bus.i_ext_rd_ready = 1'b1;
    @(negedge clk);
    bus.i_ext_rd_ready = 1'b0;
  endtask

  // Streams words base+n with the consumer always ready, recording popped beats.
  task automatic run_fill(input logic [19:0] base, input int w0, input int b0);
    int cyc;
    rf_words = w0;
    rf_beats = b0;
    rf_dones = 0;
    rf_done_beat = -1;
    cyc = 0;
    while (rf_beats < 8 && cyc < 200) begin
      @(negedge clk);
      bus.i_ext_data_valid = (rf_words < 16);
      bus.i_ext_data = base + 20'(rf_words);
      bus.i_beat_ready = 1'b1;
      #1;
      if (bus.o_fill_done) begin
        rf_dones++;
        rf_done_beat = rf_beats;
      end
      if (bus.o_beat_valid) begin
        obs_data[rf_beats] = bus.o_beat_data;
        obs_idx[rf_beats] = bus.o_beat_index;
        rf_beats++;
      end
      if (bus.o_ext_data_ready && bus.i_ext_data_valid) rf_words++;
      cyc++;
    end
    @(negedge clk);
    bus.i_ext_data_valid = 1'b0;
    bus.i_beat_ready = 1'b0;
    #1;
    rf_busy_after = bus.o_busy;
  endtask

  // Feeds words with the consumer stalled until 'target' words are accepted.
  task automatic feed_until(input logic [19:0] base, input int target, output int words);
    int cyc;
    words = 0;
    cyc = 0;
    while (words < target && cyc < 50) begin
      @(negedge clk);
      bus.i_ext_data_valid = 1'b1;
      bus.i_ext_data = base + 20'(words);
      bus.i_beat_ready = 1'b0;
      #1;
      if (bus.o_ext_data_ready) words++;
      cyc++;
    end
    @(negedge clk);
    bus.i_ext_data_valid = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    n_checks++;
    if (bus.o_req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b want 1", bus.o_req_ready); end
    n_checks++;
    if (bus.o_busy !== 1'b0 || bus.o_ext_rd_valid !== 1'b0 || bus.o_ext_data_ready !== 1'b0 ||
        bus.o_beat_valid !== 1'b0 || bus.o_fill_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: busy=%b rd_valid=%b data_ready=%b beat_valid=%b done=%b want all 0",
               bus.o_busy, bus.o_ext_rd_valid, bus.o_ext_data_ready, bus.o_beat_valid, bus.o_fill_done);
    end
    n_checks++;
    if (bus.o_beat_data !== 40'h0 || bus.o_beat_index !== 3'd0 || bus.o_ext_addr !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_data: beat=%h idx=%0d addr=%h want 0", bus.o_beat_data, bus.o_beat_index, bus.o_ext_addr);
    end
    @(negedge clk);
    arst_n = 1'b1;
  endtask

  task automatic test_basic_fill;
    logic [39:0] exp_d;
    logic [2:0] exp_i;
    issue(16'hAB37);
    run_fill(20'h00000, 0, 0);
    for (int k = 0; k < 8; k++) begin
      exp_d = {20'(2*k+1), 20'(2*k)};
      exp_i = exp_base(16'hAB37) + 3'(k);
      n_checks++;
      if (obs_data[k] !== exp_d) begin n_fail++; $display("FAIL basic_beat%0d_data: got %h want %h", k, obs_data[k], exp_d); end
      n_checks++;
      if (obs_idx[k] !== exp_i) begin n_fail++; $display("FAIL basic_beat%0d_index: got %0d want %0d", k, obs_idx[k], exp_i); end
    end
    n_checks++;
    if (rf_dones != 1 || rf_done_beat != 7) begin
      n_fail++; $display("FAIL basic_fill_done: pulses=%0d at_beat=%0d want 1 at 7", rf_dones, rf_done_beat);
    end
    n_checks++;
    if (rf_busy_after !== 1'b0 || rf_words != 16) begin
      n_fail++; $display("FAIL basic_end: busy=%b words=%0d want 0 and 16", rf_busy_after, rf_words);
    end
  endtask

  task automatic test_backpressure;
    int words;
    int cyc;
    logic [39:0] exp_d;
    issue(16'h5550);
    words = 0;
    for (cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      bus.i_ext_data_valid = 1'b1;
      bus.i_ext_data = 20'h00100 + 20'(words);
      bus.i_beat_ready = 1'b0;
      #1;
      if (bus.o_ext_data_ready) words++;
    end
    n_checks++;
    if (words != 9) begin n_fail++; $display("FAIL bp_words_accepted: got %0d want 9", words); end
    n_checks++;
    if (bus.o_ext_data_ready !== 1'b0 || bus.o_beat_valid !== 1'b1) begin
      n_fail++; $display("FAIL bp_full_flags: data_ready=%b beat_valid=%b want 0 1", bus.o_ext_data_ready, bus.o_beat_valid);
    end
    @(negedge clk);
    bus.i_beat_ready = 1'b1;
    #1;
    n_checks++;
    if (bus.o_ext_data_ready !== 1'b0) begin
      n_fail++; $display("FAIL bp_ready_during_pop: got %b want 0", bus.o_ext_data_ready);
    end
    obs_data[0] = bus.o_beat_data;
    obs_idx[0] = bus.o_beat_index;
    run_fill(20'h00100, words, 1);
    for (int k = 0; k < 8; k++) begin
      exp_d = {20'h00100 + 20'(2*k+1), 20'h00100 + 20'(2*k)};
      n_checks++;
      if (obs_data[k] !== exp_d || obs_idx[k] !== 3'(k)) begin
        n_fail++; $display("FAIL bp_beat%0d: got %h idx %0d want %h idx %0d", k, obs_data[k], obs_idx[k], exp_d, k);
      end
    end
    n_checks++;
    if (rf_dones != 1 || rf_words != 16 || rf_busy_after !== 1'b0) begin
      n_fail++; $display("FAIL bp_end: done=%0d words=%0d busy=%b want 1 16 0", rf_dones, rf_words, rf_busy_after);
    end
  endtask

  task automatic test_rd_stall;
    logic [39:0] exp_d;
    @(negedge clk);
    bus.i_req_addr = 16'hAB37;
    bus.i_req_valid = 1'b1;
    @(negedge clk);
    bus.i_req_valid = 1'b0;
    bus.i_ext_rd_ready = 1'b0;
    bus.i_ext_data_valid = 1'b1;
    bus.i_ext_data = 20'hFFFFF;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      n_checks++;
      if (bus.o_ext_rd_valid !== 1'b1 || bus.o_ext_addr !== exp_ext_addr(16'hAB37) || bus.o_ext_data_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_cycle%0d: rd_valid=%b addr=%h data_ready=%b want 1 %h 0",
                 i, bus.o_ext_rd_valid, bus.o_ext_addr, bus.o_ext_data_ready, exp_ext_addr(16'hAB37));
      end
    end
    @(negedge clk);
    bus.i_ext_rd_ready = 1'b1;
    bus.i_ext_data_valid = 1'b0;
    @(negedge clk);
    bus.i_ext_rd_ready = 1'b0;
    #1;
    n_checks++;
    if (bus.o_ext_rd_valid !== 1'b0 || bus.o_ext_data_ready !== 1'b1) begin
      n_fail++; $display("FAIL stall_after_handshake: rd_valid=%b data_ready=%b want 0 1", bus.o_ext_rd_valid, bus.o_ext_data_ready);
    end
    run_fill(20'h00000, 0, 0);
    exp_d = {20'h00001, 20'h00000};
    n_checks++;
    if (obs_data[0] !== exp_d || obs_idx[0] !== exp_base(16'hAB37)) begin
      n_fail++; $display("FAIL stall_first_beat: got %h idx %0d want %h idx %0d", obs_data[0], obs_idx[0], exp_d, exp_base(16'hAB37));
    end
    n_checks++;
    if (rf_dones != 1 || rf_words != 16 || rf_busy_after !== 1'b0) begin
      n_fail++; $display("FAIL stall_end: done=%0d words=%0d busy=%b want 1 16 0", rf_dones, rf_words, rf_busy_after);
    end
  endtask

  task automatic test_halt;
    int words;
    logic [39:0] exp_d;
    issue(16'h2220);
    feed_until(20'h00200, 3, words);
    halt = 1'b1;
    bus.i_ext_data_valid = 1'b1;
    bus.i_ext_data = 20'h00203;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      n_checks++;
      if (bus.o_ext_data_ready !== 1'b0 || bus.o_req_ready !== 1'b0 || bus.o_beat_valid !== 1'b1 ||
          bus.o_beat_data !== {20'h00201, 20'h00200}) begin
        n_fail++;
        $display("FAIL halt_cycle%0d: data_ready=%b req_ready=%b beat_valid=%b beat=%h want 0 0 1 %h",
                 i, bus.o_ext_data_ready, bus.o_req_ready, bus.o_beat_valid, bus.o_beat_data, {20'h00201, 20'h00200});
      end
    end
    @(negedge clk);
    halt = 1'b0;
    bus.i_ext_data_valid = 1'b0;
    #1;
    n_checks++;
    if (bus.o_ext_data_ready !== 1'b1) begin n_fail++; $display("FAIL halt_release_ready: got %b want 1", bus.o_ext_data_ready); end
    run_fill(20'h00200, words, 0);
    for (int k = 0; k < 8; k++) begin
      exp_d = {20'h00200 + 20'(2*k+1), 20'h00200 + 20'(2*k)};
      n_checks++;
      if (obs_data[k] !== exp_d) begin n_fail++; $display("FAIL halt_beat%0d: got %h want %h", k, obs_data[k], exp_d); end
    end
    n_checks++;
    if (rf_words != 16 || rf_dones != 1) begin
      n_fail++; $display("FAIL halt_end: words=%0d done=%0d want 16 1", rf_words, rf_dones);
    end
  endtask

  task automatic test_async_reset;
    int words;
    logic [39:0] exp_d;
    issue(16'h4440);
    feed_until(20'h00400, 5, words);
    arst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.o_busy !== 1'b0 || bus.o_req_ready !== 1'b1 || bus.o_beat_valid !== 1'b0 ||
        bus.o_beat_data !== 40'h0 || bus.o_ext_addr !== 16'h0) begin
      n_fail++;
      $display("FAIL arst_outputs: busy=%b req_ready=%b beat_valid=%b beat=%h addr=%h want 0 1 0 0 0",
               bus.o_busy, bus.o_req_ready, bus.o_beat_valid, bus.o_beat_data, bus.o_ext_addr);
    end
    @(negedge clk);
    arst_n = 1'b1;
    bus.i_ext_data_valid = 1'b1;
    bus.i_ext_data = 20'h00405;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      n_checks++;
      if (bus.o_ext_data_ready !== 1'b0 || bus.o_busy !== 1'b0) begin
        n_fail++; $display("FAIL arst_ignore%0d: data_ready=%b busy=%b want 0 0", i, bus.o_ext_data_ready, bus.o_busy);
      end
    end
    bus.i_ext_data_valid = 1'b0;
    issue(16'h1230);
    run_fill(20'h00300, 0, 0);
    for (int k = 0; k < 8; k++) begin
      exp_d = {20'h00300 + 20'(2*k+1), 20'h00300 + 20'(2*k)};
      n_checks++;
      if (obs_data[k] !== exp_d || obs_idx[k] !== 3'(k)) begin
        n_fail++; $display("FAIL arst_refill_beat%0d: got %h idx %0d want %h idx %0d", k, obs_data[k], obs_idx[k], exp_d, k);
      end
    end
    n_checks++;
    if (rf_dones != 1 || rf_busy_after !== 1'b0) begin
      n_fail++; $display("FAIL arst_refill_end: done=%0d busy=%b want 1 0", rf_dones, rf_busy_after);
    end
  endtask

  initial begin
    bus.i_req_addr = '0;
    bus.i_req_valid = 1'b0;
    bus.i_ext_rd_ready = 1'b0;
    bus.i_ext_data = '0;
    bus.i_ext_data_valid = 1'b0;
    bus.i_beat_ready = 1'b0;
    test_reset();
    test_basic_fill();
    test_backpressure();
    test_rd_stall();
    test_halt();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
